// File: rtl/apb_m_if.sv
// APB3 requester: turns a valid/ready command into one IDLE/SETUP/ACCESS transfer
// and reports completion (read data or timeout error) on a one-cycle strobe.
module apb_m_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  // TIMEOUT=0 disables the abort; keep a 1-bit counter so widths stay legal
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_WIDTH-1:0]   paddr_nxt;
  logic [DATA_WIDTH-1:0]   pwdata_nxt;
  logic                    rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;

  assign cmd_ready = (state == ST_IDLE);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      pwrite    <= pwrite_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    psel_nxt      = psel;
    penable_nxt   = penable;
    pwrite_nxt    = pwrite;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt   = ST_SETUP;
          paddr_nxt   = cmd_addr;
          pwdata_nxt  = cmd_wdata;
          pwrite_nxt  = cmd_write;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
        end
      end
      ST_SETUP: begin
        state_nxt   = ST_ACCESS;
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
      end
      ST_ACCESS: begin
        // pready on the final wait cycle still counts as a normal completion
        if (pready) begin
          state_nxt     = ST_IDLE;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_rdata_nxt = pwrite ? '0 : prdata;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          state_nxt     = ST_IDLE;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_rdata_nxt = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_m_if.sv
// Bench for apb_m_if: directed commands, a simple APB slave model and a response
// scoreboard; a second instance with TIMEOUT=0 covers the no-abort case.
module tb_apb_m_if;
  localparam int AW = 32;
  localparam int DW = 32;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready;

  logic          n_cmd_valid, n_cmd_ready, n_cmd_write;
  logic [AW-1:0] n_cmd_addr;
  logic [DW-1:0] n_cmd_wdata;
  logic          n_rsp_valid, n_rsp_err;
  logic [DW-1:0] n_rsp_rdata;
  logic          n_psel, n_penable, n_pwrite;
  logic [AW-1:0] n_paddr;
  logic [DW-1:0] n_pwdata, n_prdata;
  logic          n_pready;

  apb_m_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) u_dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  apb_m_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) u_dut_nt (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(n_cmd_valid), .cmd_ready(n_cmd_ready), .cmd_write(n_cmd_write),
    .cmd_addr(n_cmd_addr), .cmd_wdata(n_cmd_wdata),
    .rsp_valid(n_rsp_valid), .rsp_rdata(n_rsp_rdata), .rsp_err(n_rsp_err),
    .psel(n_psel), .penable(n_penable), .pwrite(n_pwrite), .paddr(n_paddr),
    .pwdata(n_pwdata), .prdata(n_prdata), .pready(n_pready)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge pclk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // expected responses: {rsp_err, rsp_rdata}
  logic [DW:0] exp_q[$];
  logic [DW:0] exp0_q[$];

  always @(negedge pclk) begin : mon_main
    logic [DW:0] e;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%0h err=%0b required no response",
                 rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        chk("rsp", {31'd0, rsp_err, rsp_rdata}, {31'd0, e});
      end
    end
  end

  always @(negedge pclk) begin : mon_nt
    logic [DW:0] e;
    if (n_rsp_valid) begin
      if (exp0_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp_nt: got rsp_valid=1 required no response");
      end else begin
        e = exp0_q.pop_front();
        chk("rsp_nt", {31'd0, n_rsp_err, n_rsp_rdata}, {31'd0, e});
      end
    end
  end

  // APB slave model: pready asserted once wait_n ACCESS cycles have elapsed
  int            wait_n = 0;
  logic [DW-1:0] slv_rdata = '0;
  int            acc_cnt = 0;
  int            last_acc = 0;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_wdata = '0;
  logic          s_write = 1'b0;
  logic [AW-1:0] addr_log[$];

  initial begin
    pready = 1'b0;
    prdata = '0;
  end

  always @(negedge pclk) begin
    if (psel && !penable) begin
      s_addr  = paddr;
      s_wdata = pwdata;
      s_write = pwrite;
      addr_log.push_back(paddr);
    end
    if (psel && penable) begin
      acc_cnt++;
      chk("access_hold", {paddr, pwdata}, {s_addr, s_wdata});
      chk("access_dir", {63'd0, pwrite}, {63'd0, s_write});
      pready = (acc_cnt > wait_n);
      prdata = slv_rdata;
    end else begin
      if (acc_cnt != 0) last_acc = acc_cnt;
      acc_cnt = 0;
      pready  = 1'b0;
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got cmd_ready=0 required 1 within 50 cycles");
    end
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge pclk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_cyc[3];
    int n;
    logic ok;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    n_cmd_valid = 0; n_cmd_write = 0; n_cmd_addr = '0; n_cmd_wdata = '0;
    n_prdata = '0; n_pready = 0;

    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("rst_apb", {60'd0, psel, penable, pwrite, rsp_valid}, 64'd0);
    chk("rst_addr_data", {paddr, pwdata}, 64'd0);
    chk("rst_rsp", {31'd0, rsp_err, rsp_rdata}, 64'd0);
    chk("rst_ready", {63'd0, cmd_ready}, 64'd1);

    // 1: zero-wait write, cycle-exact timing
    wait_n = 0;
    exp_q.push_back({1'b0, 32'h0});
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h2; cmd_wdata = 32'hDEADBEEF;
    @(negedge pclk);
    cmd_valid = 0;
    chk("t1_setup", {61'd0, psel, penable, cmd_ready}, {61'd0, 3'b100});
    chk("t1_addr_data", {paddr, pwdata}, {32'h2, 32'hDEADBEEF});
    chk("t1_pwrite", {63'd0, pwrite}, 64'd1);
    @(negedge pclk);
    chk("t1_access", {62'd0, psel, penable}, {62'd0, 2'b11});
    @(negedge pclk);
    chk("t1_done", {60'd0, psel, penable, rsp_valid, cmd_ready}, {60'd0, 4'b0011});
    @(negedge pclk);
    chk("t1_pulse", {63'd0, rsp_valid}, 64'd0);
    drain();

    // 2: read with three wait states
    wait_n = 3;
    slv_rdata = 32'h12345678;
    exp_q.push_back({1'b0, 32'h12345678});
    issue(1'b0, 32'h1, 32'h0);
    drain();
    @(negedge pclk);
    chk("t2_access_cycles", 64'(last_acc), 64'd4);
    repeat (2) @(negedge pclk);
    chk("t2_rdata_held", {31'd0, rsp_valid, rsp_rdata}, {31'd0, 1'b0, 32'h12345678});

    // 3: timeout abort after exactly four ACCESS cycles, then a normal write
    wait_n = 1000;
    exp_q.push_back({1'b1, 32'h0});
    issue(1'b0, 32'h5, 32'h0);
    drain();
    @(negedge pclk);
    chk("t3_access_cycles", 64'(last_acc), 64'd4);
    chk("t3_err_held", {63'd0, rsp_err}, 64'd1);
    wait_n = 0;
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 32'h7, 32'h55);
    drain();
    @(negedge pclk);
    chk("t3_next_ok", 64'(last_acc), 64'd1);

    // 4: back-to-back writes with cmd_valid held high
    addr_log.delete();
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1; cmd_write = 1;
      cmd_addr  = 32'h10 + 32'(4 * i);
      cmd_wdata = 32'(i + 1);
      n = 0;
      while (!cmd_ready && n < 20) begin
        @(negedge pclk);
        n++;
      end
      rdy_cyc[i] = cyc;
      exp_q.push_back({1'b0, 32'h0});
      @(negedge pclk);
    end
    cmd_valid = 0;
    drain();
    chk("t4_gap01", 64'(rdy_cyc[1] - rdy_cyc[0]), 64'd3);
    chk("t4_gap12", 64'(rdy_cyc[2] - rdy_cyc[1]), 64'd3);
    chk("t4_count", 64'(addr_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < addr_log.size(); i++)
      chk("t4_addr_order", {32'd0, addr_log[i]}, 64'h10 + 64'(4 * i));

    // 5: reset during ACCESS, no response may appear
    wait_n = 1000;
    issue(1'b0, 32'h9, 32'h0);
    n = 0;
    while (!penable && n < 10) begin
      @(negedge pclk);
      n++;
    end
    @(negedge pclk);
    chk("t5_in_access", {62'd0, psel, penable}, {62'd0, 2'b11});
    presetn = 1'b0;
    #1;
    chk("t5_async_drop", {61'd0, psel, penable, rsp_valid}, 64'd0);
    chk("t5_ready_in_rst", {63'd0, cmd_ready}, 64'd1);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    wait_n = 0;
    repeat (10) @(negedge pclk);
    chk("t5_after_rst", {61'd0, cmd_ready, psel, rsp_valid}, {61'd0, 3'b100});
    slv_rdata = 32'hA5A5;
    exp_q.push_back({1'b0, 32'hA5A5});
    issue(1'b0, 32'hB, 32'h0);
    drain();

    // 6: TIMEOUT=0 never aborts
    exp0_q.push_back({1'b0, 32'hCAFEF00D});
    n_prdata = 32'hCAFEF00D;
    n_pready = 0;
    n_cmd_valid = 1; n_cmd_write = 0; n_cmd_addr = 32'h3;
    @(negedge pclk);
    n_cmd_valid = 0;
    chk("t6_setup", {62'd0, n_psel, n_penable}, {62'd0, 2'b10});
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk);
      if (!(n_psel && n_penable && !n_rsp_valid)) ok = 1'b0;
    end
    chk("t6_no_abort", {63'd0, ok}, 64'd1);
    n_pready = 1;
    @(negedge pclk);
    n_pready = 0;
    chk("t6_done", {61'd0, n_psel, n_penable, n_rsp_valid}, {61'd0, 3'b001});
    n = 0;
    while (exp0_q.size() != 0 && n < 20) begin
      @(negedge pclk);
      n++;
    end
    chk("t6_drain", 64'(exp0_q.size()), 64'd0);

    repeat (3) @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
